// File: rtl/seq_match_ctrl.sv
// Programmable bit-serial pattern-match controller: holds pattern/len/overlap/target,
// detects the pattern on a qualified 1-bit stream, counts matches and signals completion.
module seq_match_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 5,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic [CNT_W-1:0]   cfg_target,
   output logic               cfg_err,
   input  logic               start,
   input  logic               abort,
   input  logic               in_valid,
   input  logic               in,
   output logic               match,
   output logic [CNT_W-1:0]   match_count,
   output logic               busy,
   output logic               done,
   output logic [1:0]         fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CFGD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic [CNT_W-1:0]   tgt_q;
   logic [MAX_LEN-1:0] shreg;
   logic [LEN_W-1:0]   fill;
   logic [CNT_W-1:0]   count_q;
   logic               err_q;

   logic [MAX_LEN-1:0] mask;
   logic [MAX_LEN-1:0] window;
   logic [LEN_W:0]     fill_p1;
   logic               fill_ok;
   logic [LEN_W-1:0]   fill_next;
   logic               pat_hit;
   logic [CNT_W-1:0]   cnt_inc;
   logic               len_legal;

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len_q));
      end
   end

   // The completing bit is not yet in shreg, so the window appends it combinationally.
   assign window    = {shreg[MAX_LEN-2:0], in};
   assign fill_p1   = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
   assign fill_ok   = (fill_p1 >= {1'b0, len_q});
   assign fill_next = fill_ok ? len_q : fill_p1[LEN_W-1:0];
   assign pat_hit   = (((window ^ pat_q) & mask) == '0);
   assign cnt_inc   = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
   assign len_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

   // abort and start both pre-empt the stream bit of the same cycle.
   assign match = (state == RUN) && in_valid && !abort && !start && fill_ok && pat_hit;

   assign cfg_ready   = (state != RUN);
   assign busy        = (state == RUN);
   assign done        = (state == DONE);
   assign cfg_err     = err_q;
   assign match_count = count_q;
   assign fsm_state   = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         tgt_q   <= '0;
         shreg   <= '0;
         fill    <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (state != RUN && cfg_valid) begin
            if (len_legal) begin
               pat_q <= cfg_pattern;
               len_q <= cfg_len;
               ovl_q <= cfg_overlap;
               tgt_q <= cfg_target;
               state <= CFGD;
            end else begin
               err_q <= 1'b1;
            end
         end
         case (state)
            CFGD, DONE: begin
               if (state == DONE && abort) begin
                  state <= CFGD;
                  fill  <= '0;
               end else if (start) begin
                  state   <= RUN;
                  count_q <= '0;
                  fill    <= '0;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= CFGD;
                  fill  <= '0;
               end else if (start) begin
                  count_q <= '0;
                  fill    <= '0;
               end else if (in_valid) begin
                  shreg <= window;
                  if (match) begin
                     if (!(&count_q)) count_q <= cnt_inc;
                     fill <= ovl_q ? fill_next : '0;
                     if (tgt_q != '0 && cnt_inc == tgt_q) state <= DONE;
                  end else begin
                     fill <= fill_next;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Programmable serial pattern-match controller. It configures, arms and sequences a single bit-serial sequence detector: it holds the pattern, length and overlap mode, counts matches against a target, and signals completion. It sits between a register/config master and a 1-bit qualified input stream, in place of fixed-pattern hard-coded detectors.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (2..16)
- LEN_W, 5, width of cfg_len (must hold MAX_LEN)
- CNT_W, 8, width of match counter and target
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config accepted when high with cfg_valid; equals (state != RUN)
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received
- cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_target  in  CNT_W  matches to reach before done; 0 = run unbounded
- cfg_err  out  1  one-cycle pulse: handshake completed with illegal cfg_len
- start  in  1  arm/re-arm detection
- abort  in  1  stop detection
- in_valid  in  1  qualifies in
- in  in  1  serial data bit
- match  out  1  Mealy pulse, combinational, same cycle as completing bit
- match_count  out  CNT_W  matches since last start
- busy  out  1  state == RUN
- done  out  1  state == DONE

## Operation
- States: IDLE (no valid config), CFGD (configured, stopped), RUN, DONE. Reset -> IDLE.
- Config handshake (cfg_valid & cfg_ready): if 1 <= cfg_len <= MAX_LEN, store pattern/len/overlap/target, state -> CFGD; else no registers change, cfg_err pulses next cycle, state unchanged.
- IDLE: start ignored. CFGD or DONE: start clears match_count and history fill, -> RUN. Config in DONE -> CFGD, clears done.
- RUN: each in_valid cycle shifts `in` into history (shreg <= {shreg, in}), fill <= min(fill+1, len).
- match = RUN & in_valid & (fill >= len-1) & ({shreg, in} low len bits == cfg_pattern low len bits). Cycles without in_valid do not advance or match.
- On match: match_count += 1 (saturate at all-ones); overlap=1 keeps fill; overlap=0 sets fill to 0 (next match needs len fresh bits).
- If target != 0 and match_count+1 == target on a match: -> DONE, same edge as count update. DONE ignores in/in_valid; match held 0.
- abort in RUN or DONE: -> CFGD, fill cleared, match_count retained. abort in IDLE/CFGD: no effect.
- Priority in one cycle: abort > start > stream. A match in the abort cycle is masked (match=0, no count).
- cfg_valid in RUN: cfg_ready=0, no effect.

## Timing
- Reset values: cfg_ready=1, cfg_err=0, match=0, match_count=0, busy=0, done=0; stored pattern/len/target/overlap=0, fill=0, shreg=0.
- match: zero latency, same cycle as completing bit; match_count and done update on following edge.
- busy rises the cycle after start is sampled; first bit counted is the first in_valid after that edge.
- Config takes effect the edge it is accepted; cfg_err is registered (1 cycle after handshake).
- len=1: every in_valid bit equal to pattern[0] matches.

## Test plan
- Reset mid-RUN (match_count=3): all outputs return to reset values asynchronously, state IDLE; start afterwards ignored.
- pattern=3'b101, len=3, overlap=0, target=0; bits 1,0,1,0,1 -> match only on bit 3; match_count=1. Continue 0,1 -> second match on bit 7.
- Same pattern, overlap=1; bits 1,0,1,0,1 -> match on bits 3 and 5; match_count=2. in_valid gaps inserted between bits -> identical result.
- target=2, overlap=1, pattern 2'b11 len=2; bits 1,1,1,1 -> matches bits 2,3; done=1 after bit 3; bit 4 ignored; match_count=2; start -> count 0, busy=1.
- cfg_len=0 and cfg_len=MAX_LEN+1 -> cfg_err pulse, stored config unchanged, IDLE stays IDLE; cfg_valid during RUN -> cfg_ready=0, no change.
- abort and start same cycle in RUN with a completing bit -> match=0, state CFGD, count retained.
